// File: rtl/modn_count_checker.sv
// modn_count_checker: passive monitor for a mod-N counter bus. Locks onto the
// sequence 0..N-1 and reports mismatches, a saturating error count and wraps.
`default_nettype none

module modn_count_checker #(
  parameter int N     = 15,
  parameter int WIDTH = 4,
  parameter int ERRW  = 8,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  output logic             locked,
  output logic [WIDTH-1:0] exp_count,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WRAPW-1:0] wrap_count
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  // One extra bit so that N == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   C_N    = N[WIDTH:0];
  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(N - 1);

  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] x);
    return (x == C_LAST) ? '0 : x + WIDTH'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  logic [WRAPW-1:0] wrap_q, wrap_d;

  logic             w_in_range;
  logic             w_match;

  assign w_in_range = ({1'b0, count_in} < C_N);
  assign w_match    = (count_in == f_next(last_q));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_d      = wrap_q;
    if (count_valid) begin
      case (state_q)
        S_UNLOCKED: begin
          if (w_in_range) begin
            last_d  = count_in;
            state_d = S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (!w_in_range) begin
            state_d = S_UNLOCKED;
          end else begin
            last_d = count_in;
            if (w_match) state_d = S_LOCKED;
          end
        end
        S_LOCKED: begin
          // f_next() is always < N, so a match implies an in-range value.
          if (w_match) begin
            last_d = count_in;
            if (last_q == C_LAST) wrap_d = wrap_q + WRAPW'(1);
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRW'(1);
            if (w_in_range) begin
              state_d = S_ACQUIRE;
              last_d  = count_in;
            end else begin
              state_d = S_UNLOCKED;
            end
          end
        end
        default: state_d = S_UNLOCKED;
      endcase
    end
    locked_d = (state_d == S_LOCKED);
    exp_d    = (state_d == S_UNLOCKED) ? '0 : f_next(last_d);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_UNLOCKED;
      last_q      <= '0;
      locked_q    <= 1'b0;
      exp_q       <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      wrap_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      locked_q    <= locked_d;
      exp_q       <= exp_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      wrap_q      <= wrap_d;
    end
  end

  assign locked     = locked_q;
  assign exp_count  = exp_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_cnt_q;
  assign wrap_count = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_modn_count_checker.sv
// Directed self-checking bench for modn_count_checker (N=15, WIDTH=4, ERRW=8).
`default_nettype none

module tb_modn_count_checker;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] count_in;
  logic       count_valid;
  logic       locked;
  logic [3:0] exp_count;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  modn_count_checker #(.N(15), .WIDTH(4), .ERRW(8), .WRAPW(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .count_in   (count_in),
    .count_valid(count_valid),
    .locked     (locked),
    .exp_count  (exp_count),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [3:0] val);
    @(negedge clk);
    count_valid = v;
    count_in    = val;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic l, input logic [3:0] e,
                           input logic p, input logic [7:0] ec, input logic [7:0] w);
    check({tag, ".locked"}, 32'(locked), 32'(l));
    check({tag, ".exp"},    32'(exp_count), 32'(e));
    check({tag, ".pulse"},  32'(err_pulse), 32'(p));
    check({tag, ".errcnt"}, 32'(err_count), 32'(ec));
    check({tag, ".wrap"},   32'(wrap_count), 32'(w));
  endtask

  initial begin
    resetn = 1'b0; count_valid = 1'b0; count_in = '0;
    step(1'b0, 4'd0);
    step(1'b1, 4'd3);
    check_all("reset", 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);

    resetn = 1'b1;
    step(1'b1, 4'd15);
    check_all("unlocked_oor", 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);

    // Two full passes 0..14
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 15; k++) begin
        step(1'b1, 4'(k));
        check_all($sformatf("seq_p%0d_k%0d", pass, k),
                  (pass == 0 && k == 0) ? 1'b0 : 1'b1,
                  4'((k + 1) % 15), 1'b0, 8'd0, 8'(pass));
      end
    end

    for (int k = 0; k <= 5; k++) step(1'b1, 4'(k));
    check_all("at5", 1'b1, 4'd6, 1'b0, 8'd0, 8'd2);

    step(1'b1, 4'd9);
    check_all("inject9", 1'b0, 4'd10, 1'b1, 8'd1, 8'd2);
    step(1'b1, 4'd10);
    check_all("relock10", 1'b1, 4'd11, 1'b0, 8'd1, 8'd2);
    step(1'b1, 4'd11);
    check_all("at11", 1'b1, 4'd12, 1'b0, 8'd1, 8'd2);

    step(1'b1, 4'd15);
    check_all("inject15", 1'b0, 4'd0, 1'b1, 8'd2, 8'd2);
    step(1'b1, 4'd3);
    check_all("acq3", 1'b0, 4'd4, 1'b0, 8'd2, 8'd2);
    step(1'b1, 4'd4);
    check_all("relock4", 1'b1, 4'd5, 1'b0, 8'd2, 8'd2);

    for (int k = 5; k <= 7; k++) step(1'b1, 4'(k));
    check_all("at7", 1'b1, 4'd8, 1'b0, 8'd2, 8'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)));
      check_all($sformatf("hold%0d", i), 1'b1, 4'd8, 1'b0, 8'd2, 8'd2);
    end
    step(1'b1, 4'd8);
    check_all("resume8", 1'b1, 4'd9, 1'b0, 8'd2, 8'd2);

    step(1'b1, 4'd3);
    check_all("inject3", 1'b0, 4'd4, 1'b1, 8'd3, 8'd2);
    step(1'b1, 4'd4);
    check_all("relock4b", 1'b1, 4'd5, 1'b0, 8'd3, 8'd2);
    step(1'b1, 4'd4);
    check_all("held4", 1'b0, 4'd5, 1'b1, 8'd4, 8'd2);
    step(1'b1, 4'd5);
    check_all("relock5", 1'b1, 4'd6, 1'b0, 8'd4, 8'd2);

    resetn = 1'b0;
    step(1'b1, 4'd6);
    check_all("midreset", 1'b0, 4'd0, 1'b0, 8'd0, 8'd0);
    resetn = 1'b1;
    step(1'b1, 4'd6);
    check_all("post_rst6", 1'b0, 4'd7, 1'b0, 8'd0, 8'd0);
    step(1'b1, 4'd7);
    check_all("post_rst7", 1'b1, 4'd8, 1'b0, 8'd0, 8'd0);

    // 300 errors via (0,1) mismatch / re-lock pairs; count must saturate at 255
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 4'd0);
      check($sformatf("sat_pulse%0d", i), 32'(err_pulse), 32'd1);
      check($sformatf("sat_cnt%0d", i), 32'(err_count), (i > 255) ? 32'd255 : 32'(i));
      step(1'b1, 4'd1);
      check($sformatf("sat_lock%0d", i), 32'(locked), 32'd1);
    end
    check_all("sat_end", 1'b1, 4'd2, 1'b0, 8'd255, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
